signed_mul_seq_arb: RTL and testbench

- Sequencer and two-requester arbiter for the k-bit right-shift signed multiplier datapath.
- Accepts operand pairs from two requesters over valid/ready and grants the single multiplier round-robin.
- Drives the datapath's start/sel/done controls, performs the final-step subtract for two's-complement multipliers, captures the product and returns it on the winner's response channel.

---
 rtl/mul_ctrl_pkg.sv | 14 +
 rtl/rr_arb2.sv | 18 +
 rtl/signed_mul_seq_arb.sv | 118 +++++++++++
 tb/tb_signed_mul_seq_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - shared states and constants for the multiplier sequencer
package mul_ctrl_pkg;

    localparam int NREQ = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAP,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter, pointer marks the preferred requester
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        winner = valid[ptr] ? ptr : ~ptr;
        gnt    = 2'b00;
        if (en && (valid != 2'b00)) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/signed_mul_seq_arb.sv
// rtl/signed_mul_seq_arb.sv - arbitrates two requesters onto one right-shift signed multiplier
module signed_mul_seq_arb
    import mul_ctrl_pkg::*;
#(
    parameter int K  = 3,
    parameter int CW = $clog2(K) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*K-1:0]   req_a,
    input  logic [NREQ*K-1:0]   req_b,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [2*K-1:0]      rsp_product,
    output logic                mul_start,
    output logic                mul_sel,
    output logic                mul_done,
    output logic [K-1:0]        mul_m_cand,
    output logic [K-1:0]        mul_m_ier,
    input  logic [2*K:0]        mul_result
);

    state_t          state, state_n;
    logic            rr_ptr;
    logic [CW-1:0]   count;
    logic [K-1:0]    a_q, b_q;
    logic            grant_q;
    logic [2*K-1:0]  product_q;
    logic [1:0]      arb_gnt;
    logic            arb_win;
    logic            grant_fire;
    logic            unused_result_msb;

    // The datapath's extra guard bit never carries product information.
    assign unused_result_msb = mul_result[2*K];

    rr_arb2 u_arb (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .en     ((state == IDLE) && !rst),
        .gnt    (arb_gnt),
        .winner (arb_win)
    );

    assign req_ready   = arb_gnt;
    assign grant_fire  = |arb_gnt;
    assign mul_m_cand  = a_q;
    assign mul_m_ier   = b_q;
    assign rsp_product = product_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            count     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            grant_q   <= 1'b0;
            product_q <= '0;
        end else begin
            state <= state_n;
            if (grant_fire) begin
                a_q     <= arb_win ? req_a[2*K-1:K] : req_a[K-1:0];
                b_q     <= arb_win ? req_b[2*K-1:K] : req_b[K-1:0];
                grant_q <= arb_win;
                rr_ptr  <= ~arb_win;
            end
            if (state == LOAD) begin
                count <= '0;
            end else if (state == RUN) begin
                count <= count + 1'b1;
            end
            if (state == CAP) begin
                product_q <= mul_result[2*K-1:0];
            end
        end
    end

    always_comb begin
        state_n   = state;
        mul_start = 1'b0;
        mul_sel   = 1'b0;
        mul_done  = 1'b0;
        rsp_valid = '0;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                mul_start = 1'b1;
                state_n   = RUN;
            end
            RUN: begin
                // Two's-complement multiplier: the MSB step carries negative weight.
                if (count == CW'(K - 1)) begin
                    mul_sel = b_q[K-1];
                    state_n = CAP;
                end
            end
            CAP: begin
                mul_done = 1'b1;
                state_n  = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_signed_mul_seq_arb.sv
// tb/tb_signed_mul_seq_arb.sv - randomized self-checking bench with an attached shift multiplier model
module tb_signed_mul_seq_arb;

    localparam int K = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2*K-1:0]   req_a, req_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [2*K-1:0]   rsp_product;
    logic             mul_start, mul_sel, mul_done;
    logic [K-1:0]     mul_m_cand, mul_m_ier;
    logic [2*K:0]     mul_result;

    always #5 clk = ~clk;

    signed_mul_seq_arb #(.K(K)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .mul_start   (mul_start),
        .mul_sel     (mul_sel),
        .mul_done    (mul_done),
        .mul_m_cand  (mul_m_cand),
        .mul_m_ier   (mul_m_ier),
        .mul_result  (mul_result)
    );

    // Right-shift add/subtract multiplier standing in for the real datapath instance.
    logic signed [K:0] dp_p = '0;
    logic [K-1:0]      dp_q = '0;
    wire signed [K:0]  cand_x = $signed({mul_m_cand[K-1], mul_m_cand});
    wire signed [K:0]  dp_add = dp_q[0] ? (mul_sel ? -cand_x : cand_x) : '0;
    wire signed [K:0]  dp_sum = dp_p + dp_add;

    always @(posedge clk) begin
        if (mul_start) begin
            dp_p <= '0;
            dp_q <= mul_m_ier;
        end else begin
            dp_p <= dp_sum >>> 1;
            dp_q <= {dp_sum[0], dp_q[K-1:1]};
        end
    end
    assign mul_result = mul_done ? {dp_p, dp_q} : '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [K-1:0] a;
        logic [K-1:0] b;
    } op_t;

    op_t  q_exp[$];
    int   win_log[$];
    bit   busy = 0;
    bit   seen = 0;
    int   g_cyc = 0;
    int   sel_cnt = 0;
    int   rsp_cnt = 0;
    int   gnt_cnt = 0;
    int   last_win = 1;
    int   last_prod = 0;

    // Reference: whoever is valid gets served; under contention the previous winner yields.
    always @(negedge clk) begin
        int w;
        int p;
        op_t o;
        if (rst) begin
            q_exp.delete();
            busy     = 0;
            last_win = 1;
        end else if (busy) begin
            check("ready_busy", req_ready, 0);
            if (mul_sel) sel_cnt++;
            if (mul_done) begin
                check("cand_hold", mul_m_cand, q_exp[0].a);
                check("ier_hold", mul_m_ier, q_exp[0].b);
            end
            if (rsp_valid != 0) begin
                o = q_exp[0];
                if (!seen) begin
                    seen = 1;
                    check("latency", cyc - g_cyc, K + 2);
                end
                check("rsp_route", rsp_valid, 32'd1 << o.idx);
                if ((rsp_valid & rsp_ready) != 0) begin
                    p = $signed(o.a) * $signed(o.b);
                    check("product", rsp_product, p & 63);
                    check("sel_pulses", sel_cnt, o.b[K-1] ? 1 : 0);
                    last_prod = rsp_product;
                    void'(q_exp.pop_front());
                    busy = 0;
                    rsp_cnt++;
                end
            end
        end else begin
            check("rsp_idle", rsp_valid, 0);
            if (req_valid != 0) begin
                if (req_valid == 2'b11) w = 1 - last_win;
                else                    w = req_valid[1] ? 1 : 0;
                check("grant", req_ready, 32'd1 << w);
                o.idx = w;
                o.a   = w ? req_a[2*K-1:K] : req_a[K-1:0];
                o.b   = w ? req_b[2*K-1:K] : req_b[K-1:0];
                q_exp.push_back(o);
                win_log.push_back(w);
                last_win = w;
                busy     = 1;
                seen     = 0;
                sel_cnt  = 0;
                g_cyc    = cyc + 1;
                gnt_cnt++;
            end
        end
    end

    task automatic send(input int idx, input logic [K-1:0] a, input logic [K-1:0] b);
        int n0;
        bit got;
        n0 = rsp_cnt;
        req_valid[idx]   = 1'b1;
        req_a[idx*K +: K] = a;
        req_b[idx*K +: K] = b;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1;
        end
        check("grant_wait", got, 1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rsp_cnt != n0) got = 1;
        end
        check("rsp_wait", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_product"}, rsp_product, 0);
        check({tag, "_ctrl"}, {mul_start, mul_sel, mul_done}, 0);
        check({tag, "_operands"}, {mul_m_cand, mul_m_ier}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [1:0]      acc;
        logic [2*K-1:0]  held;
        bit              got;
        int              g0, n0;

        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        req_valid = 2'b11;
        #1 check_all_zero("reset");
        req_valid = 2'b00;
        @(posedge clk); #1 rst = 1'b0;

        // Basic products, including the MSB-subtract and the no-subtract cases.
        rsp_ready = 2'b11;
        send(0, 3'd3, 3'b110);
        check("t1_prod", last_prod, 6'h3A);
        send(1, 3'b100, 3'b100);
        check("t2a_prod", last_prod, 6'h10);
        send(0, 3'b100, 3'd3);
        check("t2b_prod", last_prod, 6'h34);

        // Constant contention from reset: grants must alternate starting with 0.
        do_reset();
        win_log.delete();
        g0 = gnt_cnt;
        req_a = 6'($urandom); req_b = 6'($urandom);
        req_valid = 2'b11;
        for (int i = 0; i < 300 && gnt_cnt < g0 + 8; i++) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk); #1;
            for (int j = 0; j < 2; j++) begin
                if (acc[j]) begin
                    req_a[j*K +: K] = 3'($urandom);
                    req_b[j*K +: K] = 3'($urandom);
                end
            end
        end
        req_valid = 2'b00;
        check("t3_grant_count", gnt_cnt - g0, 8);
        for (int i = 0; i < 4; i++) check("t3_order", win_log[i], i % 2);
        for (int i = 0; i < 40 && busy; i++) @(posedge clk);
        #1;

        // Backpressure: response must hold steady and nothing else may be granted.
        rsp_ready = 2'b00;
        n0 = rsp_cnt;
        req_valid[0] = 1'b1; req_a[K-1:0] = 3'b101; req_b[K-1:0] = 3'b011;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1;
        end
        @(posedge clk); #1 req_valid = 2'b11;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) got = 1;
        end
        check("t4_rsp_seen", got, 1);
        held = rsp_product;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 2'b01);
            check("t4_hold_prod", rsp_product, held);
            check("t4_hold_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < 10 && rsp_cnt == n0; i++) @(posedge clk);
        check("t4_delivered", rsp_cnt - n0, 1);
        check("t4_prod", last_prod, 6'h37);

        // Reset in RUN aborts silently; the following op still works.
        @(posedge clk); #1;
        n0 = rsp_cnt;
        req_valid[0] = 1'b1; req_a[K-1:0] = 3'd2; req_b[K-1:0] = 3'd3;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1;
        end
        @(posedge clk); #1 req_valid = 2'b00;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 check_all_zero("t5_abort");
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("t5_no_rsp", rsp_cnt - n0, 0);
        send(0, 3'b101, 3'b111);
        check("t5_prod", last_prod, 6'h03);

        // Exhaustive operand sweep through requester 0.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                send(0, 3'(a), 3'(b));
            end
        end

        // Random traffic on both requesters with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_a     = 6'($urandom);
            req_b     = 6'($urandom);
            rsp_ready = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < 40 && busy; i++) @(posedge clk);
        #1 check("drain", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
